guess_game: RTL and testbench

- Controller for the number-guessing game, directly downstream of the 50 MHz clock divider.
- Runs on the 50 MHz board clock and consumes the divider's slow square wave as a timing enable. It does not use that wave as a clock.
- Generates a pseudo-random secret and accepts guesses from switches on button presses.
- Drives higher/lower/correct hints, a try counter and win/lose status, and enforces a per-guess timeout measured in slow-clock periods.

---
 rtl/guess_pkg.sv | 21 ++
 rtl/sync_edge.sv | 26 ++
 rtl/guess_game.sv | 123 ++++++++++++
 tb/tb_guess_game.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/guess_pkg.sv
// Shared types and constants for the number-guessing game controller.
// Holds the FSM state encoding, LFSR tap mask and tries-counter width.
package guess_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_GUESS = 3'd1,
    CHECK      = 3'd2,
    WIN        = 3'd3,
    LOSE       = 3'd4
  } state_t;

  // x^8+x^6+x^5+x^4+1 as a Fibonacci feedback mask over bits [7:0]
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  localparam int         TRIES_W   = 4;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer plus rising-edge detector; the pulse is valid
// for one cycle, two clock edges after the asynchronous input rises.
module sync_edge (
  input  logic iclk,
  input  logic irst_n,
  input  logic iasync,
  output logic opulse
);

  logic s1, s2, s3;

  always_ff @(posedge iclk) begin
    if (!irst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= iasync;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign opulse = s2 & ~s3;

endmodule

// File: rtl/guess_game.sv
// Number-guessing game FSM: LFSR secret, hints, try counter and a guess
// timeout counted in slow-clock rising edges (used as an enable, not a clock).
module guess_game
  import guess_pkg::*;
#(
  parameter int         W             = 4,
  parameter int         MAX_TRIES     = 5,
  parameter int         TIMEOUT_TICKS = 10,
  parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
  input  logic         iclk,
  input  logic         irst_n,
  input  logic         islow,
  input  logic         ibtn,
  input  logic [W-1:0] iguess,
  output logic         ohigher,
  output logic         olower,
  output logic         ocorrect,
  output logic         olose,
  output logic [3:0]   otries,
  output logic [W-1:0] osecret,
  output logic         oplaying
);

  logic               tick;
  logic               press;
  state_t             state;
  logic [7:0]         lfsr;
  logic [W-1:0]       secret;
  logic [W-1:0]       guess_reg;
  logic [7:0]         timeout;
  logic [7:0]         timeout_inc;
  logic [TRIES_W-1:0] tries_inc;

  sync_edge u_slow (.iclk(iclk), .irst_n(irst_n), .iasync(islow), .opulse(tick));
  sync_edge u_btn  (.iclk(iclk), .irst_n(irst_n), .iasync(ibtn),  .opulse(press));

  assign timeout_inc = timeout + 8'd1;
  assign tries_inc   = (otries == '1) ? otries : otries + 1'b1;

  always_ff @(posedge iclk) begin
    if (!irst_n) begin
      state     <= IDLE;
      lfsr      <= LFSR_SEED;
      secret    <= '0;
      guess_reg <= '0;
      timeout   <= '0;
      otries    <= '0;
      ohigher   <= 1'b0;
      olower    <= 1'b0;
      ocorrect  <= 1'b0;
      olose     <= 1'b0;
      osecret   <= '0;
      oplaying  <= 1'b0;
    end else begin
      lfsr <= lfsr_next(lfsr);
      case (state)
        IDLE: begin
          if (press) begin
            secret   <= lfsr[W-1:0];
            otries   <= '0;
            timeout  <= '0;
            ohigher  <= 1'b0;
            olower   <= 1'b0;
            oplaying <= 1'b1;
            state    <= WAIT_GUESS;
          end
        end
        WAIT_GUESS: begin
          // a press in the same cycle as a tick takes priority; the tick is dropped
          if (press) begin
            guess_reg <= iguess;
            state     <= CHECK;
          end else if (tick) begin
            timeout <= timeout_inc;
            if (timeout_inc == 8'(TIMEOUT_TICKS)) begin
              olose    <= 1'b1;
              oplaying <= 1'b0;
              osecret  <= secret;
              state    <= LOSE;
            end
          end
        end
        CHECK: begin
          if (guess_reg == secret) begin
            ocorrect <= 1'b1;
            oplaying <= 1'b0;
            osecret  <= secret;
            state    <= WIN;
          end else begin
            otries  <= tries_inc;
            ohigher <= (guess_reg < secret);
            olower  <= (guess_reg > secret);
            timeout <= '0;
            if (tries_inc == TRIES_W'(MAX_TRIES)) begin
              olose    <= 1'b1;
              oplaying <= 1'b0;
              osecret  <= secret;
              state    <= LOSE;
            end else begin
              state <= WAIT_GUESS;
            end
          end
        end
        WIN, LOSE: begin
          if (press) begin
            otries   <= '0;
            timeout  <= '0;
            ohigher  <= 1'b0;
            olower   <= 1'b0;
            ocorrect <= 1'b0;
            olose    <= 1'b0;
            osecret  <= '0;
            oplaying <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_guess_game.sv
// Scoreboard bench for guess_game: a behavioural game model queues expected
// outputs at stimulus time; they are popped and compared once the DUT responds.
module tb_guess_game;

  localparam int W             = 4;
  localparam int MAX_TRIES     = 5;
  localparam int TIMEOUT_TICKS = 10;

  logic         iclk   = 1'b0;
  logic         irst_n = 1'b0;
  logic         islow  = 1'b0;
  logic         ibtn   = 1'b0;
  logic [W-1:0] iguess = '0;
  logic         ohigher, olower, ocorrect, olose, oplaying;
  logic [3:0]   otries;
  logic [W-1:0] osecret;

  guess_game #(
    .W(W), .MAX_TRIES(MAX_TRIES), .TIMEOUT_TICKS(TIMEOUT_TICKS), .LFSR_SEED(8'hA5)
  ) dut (
    .iclk(iclk), .irst_n(irst_n), .islow(islow), .ibtn(ibtn), .iguess(iguess),
    .ohigher(ohigher), .olower(olower), .ocorrect(ocorrect), .olose(olose),
    .otries(otries), .osecret(osecret), .oplaying(oplaying)
  );

  always #10 iclk = ~iclk;

  typedef struct packed {
    logic         higher;
    logic         lower;
    logic         correct;
    logic         lose;
    logic [3:0]   tries;
    logic [W-1:0] secret;
    logic         playing;
  } obs_t;

  obs_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference LFSR, stepped in lockstep with the board clock
  logic [7:0] lfsr_m = 8'hA5;
  function automatic logic [7:0] step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction
  always @(posedge iclk) lfsr_m <= !irst_n ? 8'hA5 : step(lfsr_m);

  logic         m_higher, m_lower, m_correct, m_lose, m_playing;
  logic [3:0]   m_tries;
  logic [W-1:0] m_secret;
  int           m_to;

  function automatic obs_t model_obs();
    obs_t o;
    o.higher  = m_higher;
    o.lower   = m_lower;
    o.correct = m_correct;
    o.lose    = m_lose;
    o.tries   = m_tries;
    o.secret  = (m_correct | m_lose) ? m_secret : '0;
    o.playing = m_playing;
    return o;
  endfunction

  task automatic model_clear();
    m_higher = 0; m_lower = 0; m_correct = 0; m_lose = 0; m_playing = 0;
    m_tries = 0; m_to = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge iclk);
    #1;
  endtask

  task automatic compare_out(input string tag);
    obs_t e;
    chk({tag, "_qsize"}, exp_q.size(), 1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    chk({tag, "_higher"},  ohigher,  e.higher);
    chk({tag, "_lower"},   olower,   e.lower);
    chk({tag, "_correct"}, ocorrect, e.correct);
    chk({tag, "_lose"},    olose,    e.lose);
    chk({tag, "_tries"},   otries,   e.tries);
    chk({tag, "_secret"},  osecret,  e.secret);
    chk({tag, "_playing"}, oplaying, e.playing);
  endtask

  // Press from IDLE; the secret is the LFSR value two edges after the drive
  task automatic start_game(input string tag);
    logic [7:0] cap;
    ibtn = 1'b1;
    cyc(2);
    cap = lfsr_m;
    model_clear();
    m_secret  = cap[W-1:0];
    m_playing = 1;
    exp_q.push_back(model_obs());
    cyc(1);
    compare_out(tag);
    ibtn = 1'b0;
    cyc(4);
  endtask

  task automatic start_with_secret(input logic [W-1:0] target, input string tag);
    logic [7:0] ahead;
    int         n = 0;
    ahead = step(step(lfsr_m));
    while (ahead[W-1:0] != target && n < 300) begin
      cyc(1);
      n++;
      ahead = step(step(lfsr_m));
    end
    chk({tag, "_seek"}, ahead[W-1:0], target);
    start_game(tag);
  endtask

  task automatic do_guess(input logic [W-1:0] g, input bit with_tick, input string tag);
    iguess = g;
    ibtn   = 1'b1;
    if (with_tick) islow = 1'b1;
    if (g == m_secret) begin
      m_correct = 1; m_playing = 0;
    end else begin
      if (m_tries != 4'hF) m_tries++;
      m_higher = (g < m_secret);
      m_lower  = (g > m_secret);
      m_to     = 0;
      if (m_tries == MAX_TRIES) begin m_lose = 1; m_playing = 0; end
    end
    exp_q.push_back(model_obs());
    cyc(3);
    chk({tag, "_in_check"}, oplaying, 1);
    cyc(1);
    compare_out(tag);
    ibtn   = 1'b0;
    islow  = 1'b0;
    iguess = W'($urandom);
    cyc(4);
  endtask

  task automatic do_tick(input string tag);
    islow = 1'b1;
    m_to++;
    if (m_to == TIMEOUT_TICKS) begin m_lose = 1; m_playing = 0; end
    exp_q.push_back(model_obs());
    cyc(3);
    compare_out(tag);
    islow = 1'b0;
    cyc(4);
  endtask

  task automatic end_game(input string tag);
    ibtn = 1'b1;
    model_clear();
    exp_q.push_back(model_obs());
    cyc(3);
    compare_out(tag);
    ibtn = 1'b0;
    cyc(4);
  endtask

  initial begin
    int lo, hi, g;
    model_clear();
    m_secret = '0;

    // Reset and idle
    cyc(3);
    exp_q.push_back(model_obs());
    compare_out("reset");
    irst_n = 1'b1;
    exp_q.push_back(model_obs());
    cyc(100);
    compare_out("idle100");

    // Binary search to a win
    start_game("bs_start");
    lo = 0; hi = 15;
    for (int i = 0; i < 6; i++) begin
      g = (lo + hi + 1) / 2;
      do_guess(W'(g), 1'b0, "bs_guess");
      if (W'(g) == m_secret) break;
      if (W'(g) < m_secret) lo = g + 1; else hi = g - 1;
    end
    chk("bs_won", ocorrect, 1);
    end_game("bs_end");

    // Hints against a known secret of 6
    start_with_secret(4'd6, "hint_start");
    do_guess(4'd3, 1'b0, "hint_low");
    do_guess(4'd9, 1'b0, "hint_high");
    do_guess(4'd6, 1'b0, "hint_win");
    end_game("hint_end");

    // Lose on the fifth wrong guess
    start_game("tries_start");
    for (int i = 0; i < MAX_TRIES; i++)
      do_guess(m_secret + W'(i + 1), 1'b0, "tries_guess");
    end_game("tries_end");

    // Timeout lose on the tenth tick
    start_game("to_start");
    for (int i = 0; i < TIMEOUT_TICKS; i++) do_tick("to_tick");
    end_game("to_end");

    // Press and tick together on the last permitted tick: the press wins
    start_game("pt_start");
    for (int i = 0; i < TIMEOUT_TICKS - 1; i++) do_tick("pt_tick");
    do_guess(m_secret + W'(1), 1'b1, "pt_both");
    do_tick("pt_after");
    do_guess(m_secret + W'(2), 1'b0, "pt_g2");
    do_guess(m_secret + W'(3), 1'b0, "pt_g3");

    // Reset mid-game with three wrong guesses
    irst_n = 1'b0;
    model_clear();
    exp_q.push_back(model_obs());
    cyc(1);
    compare_out("midreset");
    irst_n = 1'b1;
    cyc(2);

    // A held button produces one press only
    begin
      logic [7:0] cap;
      ibtn = 1'b1;
      cyc(2);
      cap = lfsr_m;
      model_clear();
      m_secret  = cap[W-1:0];
      m_playing = 1;
      iguess    = ~cap[W-1:0];
      exp_q.push_back(model_obs());
      cyc(1000);
      compare_out("held");
      ibtn = 1'b0;
      cyc(4);
    end
    do_guess(m_secret, 1'b0, "held_win");
    end_game("held_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
